// File: rtl/blink_pkg.sv
// Shared types and constants for the iCEBreaker bring-up blinker.
package blink_pkg;

    localparam int TICK_DIV_DEFAULT = 1000;
    localparam int NUM_LEDS         = 5;

    typedef logic [2:0] led_idx_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam led_idx_t LAST_IDX = led_idx_t'(NUM_LEDS - 1);

    function automatic logic [NUM_LEDS-1:0] idx_to_onehot(input led_idx_t idx);
        logic [NUM_LEDS-1:0] one;
        one = 1;
        return one << idx;
    endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 and pulses tick for the terminal-count cycle.
module blink_tick_gen
    import blink_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic CLK,
    input  logic RST_N,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/blink_led_test.sv
// Running-light blinker for clock/reset/pinout bring-up.
// Define BLINK_TEST_BOUNCE_EN for a bounce chase instead of the default wrap chase.
module blink_led_test
    import blink_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic CLK,
    input  logic RST_N,
    output logic LEDG_N,
    output logic LEDR_N,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic LED4,
    output logic LED5
);

    logic                tick;
    led_idx_t            pos;
    led_idx_t            pos_nxt;
    logic                g;
    logic                r;
    logic [NUM_LEDS-1:0] led;

    blink_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .CLK   (CLK),
        .RST_N (RST_N),
        .tick  (tick)
    );

`ifdef BLINK_TEST_BOUNCE_EN
    dir_t dir;
    dir_t dir_nxt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        dir_nxt = dir;
        if (pos == LAST_IDX) begin
            dir_nxt = DIR_DOWN;
        end else if (pos == '0) begin
            dir_nxt = DIR_UP;
        end
        pos_nxt = (dir_nxt == DIR_UP) ? pos + 1'b1 : pos - 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dir <= DIR_UP;
        end else if (tick) begin
            dir <= dir_nxt;
        end
    end
`else
    always_comb begin
        pos_nxt = (pos == LAST_IDX) ? led_idx_t'(0) : pos + 1'b1;
    end
`endif

    // Red toggles whenever the chase lands on position 0 (4->0 wrap, 1->0 bounce).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pos <= '0;
            g   <= 1'b0;
            r   <= 1'b0;
            led <= idx_to_onehot(led_idx_t'(0));
        end else if (tick) begin
            pos <= pos_nxt;
            g   <= ~g;
            led <= idx_to_onehot(pos_nxt);
            if (pos_nxt == '0) begin
                r <= ~r;
            end
        end
    end

    assign LEDG_N = ~g;
    assign LEDR_N = ~r;
    assign LED1   = led[0];
    assign LED2   = led[1];
    assign LED3   = led[2];
    assign LED4   = led[3];
    assign LED5   = led[4];

endmodule

// File: tb/tb_blink_led_test.sv
// Directed self-checking bench for blink_led_test (TICK_DIV=4 instance plus a default-divider instance).
`timescale 1ns/1ps
module tb_blink_led_test;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_n_def;

    logic ledg_n, ledr_n, led1, led2, led3, led4, led5;
    logic dg_n, dr_n, d1, d2, d3, d4, d5;

    int checks   = 0;
    int failures = 0;
    int def_edges = 0;

    // Expected {LEDR_N, LEDG_N, LED5..LED1} after step n (index 0 = reset state).
    logic [6:0] exp_tbl [0:10];

    blink_led_test #(.TICK_DIV(4)) dut (
        .CLK(clk), .RST_N(rst_n),
        .LEDG_N(ledg_n), .LEDR_N(ledr_n),
        .LED1(led1), .LED2(led2), .LED3(led3), .LED4(led4), .LED5(led5)
    );

    blink_led_test dut_def (
        .CLK(clk), .RST_N(rst_n_def),
        .LEDG_N(dg_n), .LEDR_N(dr_n),
        .LED1(d1), .LED2(d2), .LED3(d3), .LED4(d4), .LED5(d5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {ledr_n, ledg_n, led5, led4, led3, led2, led1};
    endfunction

    function automatic logic [6:0] outs_def();
        return {dr_n, dg_n, d5, d4, d3, d2, d1};
    endfunction

    always @(posedge clk) if (rst_n_def) def_edges++;

    // One-hot invariant on both instances, sampled away from the active edge.
    always @(negedge clk) begin
        check("onehot", 32'($onehot({led5, led4, led3, led2, led1})), 32'd1);
        check("onehot_def", 32'($onehot({d5, d4, d3, d2, d1})), 32'd1);
    end

    initial begin
        exp_tbl[0] = 7'b11_00001;
`ifdef BLINK_TEST_BOUNCE_EN
        exp_tbl[1]  = 7'b10_00010;
        exp_tbl[2]  = 7'b11_00100;
        exp_tbl[3]  = 7'b10_01000;
        exp_tbl[4]  = 7'b11_10000;
        exp_tbl[5]  = 7'b10_01000;
        exp_tbl[6]  = 7'b11_00100;
        exp_tbl[7]  = 7'b10_00010;
        exp_tbl[8]  = 7'b01_00001;
        exp_tbl[9]  = 7'b00_00010;
        exp_tbl[10] = 7'b01_00100;
`else
        exp_tbl[1]  = 7'b10_00010;
        exp_tbl[2]  = 7'b11_00100;
        exp_tbl[3]  = 7'b10_01000;
        exp_tbl[4]  = 7'b11_10000;
        exp_tbl[5]  = 7'b00_00001;
        exp_tbl[6]  = 7'b01_00010;
        exp_tbl[7]  = 7'b00_00100;
        exp_tbl[8]  = 7'b01_01000;
        exp_tbl[9]  = 7'b00_10000;
        exp_tbl[10] = 7'b11_00001;
`endif

        rst_n     = 1'b0;
        rst_n_def = 1'b0;

        // Reset held with clock running.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", 32'(outs()), 32'(exp_tbl[0]));
            check("reset_hold_def", 32'(outs_def()), 32'(exp_tbl[0]));
        end

        rst_n     = 1'b1;
        rst_n_def = 1'b1;

        // Every edge for 10 steps: value only changes on multiples of TICK_DIV.
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            check($sformatf("chase_e%0d", e), 32'(outs()), 32'(exp_tbl[e / 4]));
        end

        // Advance prescaler to count 2, then reset between edges.
        repeat (2) @(negedge clk);
        check("pre_async", 32'(outs()), 32'(exp_tbl[10]));
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(outs()), 32'(exp_tbl[0]));
        repeat (2) @(negedge clk);
        check("async_hold", 32'(outs()), 32'(exp_tbl[0]));
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            check($sformatf("post_rst_e%0d", e), 32'(outs()), 32'(exp_tbl[e / 4]));
        end

        // Default divider: step 9 still showing one edge before edge 10000, step 10 after it.
        while (def_edges < 9999) @(negedge clk);
        check("def_edge9999", 32'(outs_def()), 32'(exp_tbl[9]));
        @(negedge clk);
        check("def_edge10000", 32'(outs_def()), 32'(exp_tbl[10]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
